// File: rtl/bcd_display_mux.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS snapshotted BCD digits onto a shared
// segment bus with one-hot anodes, leading-zero blanking and a per-scan SCAN_DONE pulse.
module bcd_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                    CLK,
   input  logic                    CLR,
   input  logic [4*NUM_DIGITS-1:0] BCD,
   input  logic [NUM_DIGITS-1:0]   DP,
   input  logic                    BLANK_LZ,
   output logic [6:0]              SEG,
   output logic                    SEG_DP,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic                    SCAN_DONE
);

   localparam int P_W   = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [P_W-1:0]   P_LAST   = P_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   // XOR masks that also serve as the deasserted (reset) value of each bus.
   localparam logic [NUM_DIGITS-1:0] AN_POL  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
   localparam logic [6:0]            SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;

   // Segment order {g,f,e,d,c,b,a}, asserted high.
   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   logic [P_W-1:0]          p, p_nx;
   logic [IDX_W-1:0]        idx, idx_nx;
   logic [4*NUM_DIGITS-1:0] snap_bcd, snap_bcd_nx;
   logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nx;
   logic                    first;
   logic                    last_slot, wrap;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [3:0]              cur_digit;
   logic [6:0]              seg_nx;
   logic [NUM_DIGITS-1:0]   an_nx;

   // Next state; the registered outputs are derived from it so they move with the state.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
      last_slot   = (p == P_LAST);
      wrap        = last_slot && (idx == IDX_LAST);
      p_nx        = last_slot ? '0 : p + 1'b1;
      idx_nx      = idx;
      if (last_slot)
         idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      snap_bcd_nx = (wrap || first) ? BCD : snap_bcd;
      snap_dp_nx  = (wrap || first) ? DP  : snap_dp;
   end

   always_comb begin
      // NOTE: blocking assignments here let zero_run carry from one loop iteration to the next.
      zero_run   = 1'b1;
      blank_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (snap_bcd_nx[4*i +: 4] == 4'd0);
         blank_mask[i] = zero_run;
      end
      cur_digit = snap_bcd_nx[4*idx_nx +: 4];
      seg_nx    = (BLANK_LZ && blank_mask[idx_nx]) ? 7'h00 : decode(cur_digit);
      // Slot p==0 keeps every anode off so the segment change never ghosts.
      an_nx     = (p_nx == '0) ? '0 : (NUM_DIGITS'(1) << idx_nx);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         p         <= '0;
         idx       <= '0;
         snap_bcd  <= '0;
         snap_dp   <= '0;
         first     <= 1'b1;
         AN        <= AN_POL;
         SEG       <= SEG_POL;
         SEG_DP    <= ACTIVE_LOW;
         SCAN_DONE <= 1'b0;
      end else begin
         p         <= p_nx;
         idx       <= idx_nx;
         snap_bcd  <= snap_bcd_nx;
         snap_dp   <= snap_dp_nx;
         first     <= 1'b0;
         AN        <= an_nx ^ AN_POL;
         SEG       <= seg_nx ^ SEG_POL;
         SEG_DP    <= snap_dp_nx[idx_nx] ^ ACTIVE_LOW;
         SCAN_DONE <= wrap;
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: table of display vectors, cycle model feeding a scoreboard queue,
// checked on an active-low and an active-high instance in parallel.
module tb_bcd_display_mux;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic        blank_lz;
   logic [6:0]  seg_l, seg_h;
   logic        dp_l, dp_h, done_l, done_h;
   logic [3:0]  an_l, an_h;

   always #5 clk = ~clk;

   bcd_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_lo (
      .CLK(clk), .CLR(clr), .BCD(bcd), .DP(dp), .BLANK_LZ(blank_lz),
      .SEG(seg_l), .SEG_DP(dp_l), .AN(an_l), .SCAN_DONE(done_l));

   bcd_display_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_hi (
      .CLK(clk), .CLR(clr), .BCD(bcd), .DP(dp), .BLANK_LZ(blank_lz),
      .SEG(seg_h), .SEG_DP(dp_h), .AN(an_h), .SCAN_DONE(done_h));

   // Hand-derived active-high segment patterns per digit, {d3,d2,d1,d0}.
   typedef struct {
      logic [15:0]     bcd;
      logic [3:0]      dp;
      logic [3:0][6:0] seg_nz;
      logic [3:0][6:0] seg_lz;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       done;
   } exp_t;

   typedef struct {
      int vec;
      bit blank;
   } step_t;

   vec_t  vecs [9];
   step_t steps[10];
   exp_t  sb_q [$];
   int    checks = 0;
   int    errors = 0;

   int m_p, m_idx, m_snap, cur;
   bit m_first;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an_lo"},   32'(an_l),   32'hF);
      check({tag, "_seg_lo"},  32'(seg_l),  32'h7F);
      check({tag, "_dp_lo"},   32'(dp_l),   32'h1);
      check({tag, "_done_lo"}, 32'(done_l), 32'h0);
      check({tag, "_an_hi"},   32'(an_h),   32'h0);
      check({tag, "_seg_hi"},  32'(seg_h),  32'h0);
      check({tag, "_dp_hi"},   32'(dp_h),   32'h0);
      check({tag, "_done_hi"}, 32'(done_h), 32'h0);
   endtask

   task automatic set_vec(input int v);
      cur = v;
      bcd = vecs[v].bcd;
      dp  = vecs[v].dp;
   endtask

   task automatic model_reset();
      m_p     = 0;
      m_idx   = 0;
      m_snap  = 0;
      m_first = 1'b1;
   endtask

   // Predict the outputs after the next rising edge, push them, then compare on the falling edge.
   task automatic tick();
      exp_t       e;
      bit         wrap;
      logic [3:0] an_inv;
      logic [6:0] seg_inv;
      wrap = (m_p == DIV - 1) && (m_idx == N - 1);
      if (wrap || m_first) m_snap = cur;
      m_first = 1'b0;
      if (m_p == DIV - 1) begin
         m_p   = 0;
         m_idx = (m_idx + 1) % N;
      end else begin
         m_p = m_p + 1;
      end
      e.an   = (m_p == 0) ? 4'h0 : 4'(1 << m_idx);
      e.seg  = blank_lz ? vecs[m_snap].seg_lz[m_idx] : vecs[m_snap].seg_nz[m_idx];
      e.dp   = vecs[m_snap].dp[m_idx];
      e.done = wrap;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'h1, 32'h0);
      end else begin
         e       = sb_q.pop_front();
         an_inv  = ~e.an;
         seg_inv = ~e.seg;
         check("an_lo",   32'(an_l),   32'(an_inv));
         check("seg_lo",  32'(seg_l),  32'(seg_inv));
         check("dp_lo",   32'(dp_l),   32'(!e.dp));
         check("done_lo", 32'(done_l), 32'(e.done));
         check("an_hi",   32'(an_h),   32'(e.an));
         check("seg_hi",  32'(seg_h),  32'(e.seg));
         check("dp_hi",   32'(dp_h),   32'(e.dp));
         check("done_hi", 32'(done_h), 32'(e.done));
      end
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}};
      vecs[1] = '{16'h0070, 4'b0000, {7'h3F, 7'h3F, 7'h07, 7'h3F}, {7'h00, 7'h00, 7'h07, 7'h3F}};
      vecs[2] = '{16'h1111, 4'b0101, {7'h06, 7'h06, 7'h06, 7'h06}, {7'h06, 7'h06, 7'h06, 7'h06}};
      vecs[3] = '{16'h9999, 4'b1010, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, {7'h6F, 7'h6F, 7'h6F, 7'h6F}};
      vecs[4] = '{16'h00A0, 4'b1000, {7'h3F, 7'h3F, 7'h40, 7'h3F}, {7'h00, 7'h00, 7'h40, 7'h3F}};
      vecs[5] = '{16'h8888, 4'b1111, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
      vecs[6] = '{16'h5060, 4'b0000, {7'h6D, 7'h3F, 7'h7D, 7'h3F}, {7'h6D, 7'h3F, 7'h7D, 7'h3F}};
      vecs[7] = '{16'hF00E, 4'b0010, {7'h40, 7'h3F, 7'h3F, 7'h40}, {7'h40, 7'h3F, 7'h3F, 7'h40}};
      vecs[8] = '{16'h0000, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F}};

      steps[0] = '{1, 1'b1};
      steps[1] = '{1, 1'b0};
      steps[2] = '{2, 1'b0};
      steps[3] = '{3, 1'b0};
      steps[4] = '{4, 1'b1};
      steps[5] = '{6, 1'b1};
      steps[6] = '{7, 1'b1};
      steps[7] = '{8, 1'b1};
      steps[8] = '{8, 1'b0};
      steps[9] = '{5, 1'b0};

      set_vec(0);
      blank_lz = 1'b0;
      #12;
      check_reset_outputs("reset");

      // Display 1234, several scans so SCAN_DONE is seen repeatedly.
      @(negedge clk);
      clr = 1'b1;
      model_reset();
      repeat (40) tick();

      // Shift phase so every later input change lands while digit 1 is on.
      repeat (13) tick();

      for (int s = 0; s < 10; s++) begin
         set_vec(steps[s].vec);
         blank_lz = steps[s].blank;
         repeat (32) tick();
      end

      // Reset during digit 2, p=2.
      set_vec(0);
      blank_lz = 1'b0;
      for (int k = 0; k < 2 * N * DIV && !(m_idx == 2 && m_p == 2); k++) tick();
      check("reach_idx2_p2", 32'((m_idx == 2) && (m_p == 2)), 32'h1);
      #2 clr = 1'b0;
      #1 check_reset_outputs("mid_reset");
      @(negedge clk);
      check_reset_outputs("held_reset");
      clr = 1'b1;
      model_reset();
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
